fp_loader: RTL and testbench

FP_LOADER -- requirements
Module: fp_loader

---
 rtl/fp_loader.sv | 94 +++++++++
 tb/tb_fp_loader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_loader.sv
// fp_loader: hex-keypad front panel that edits a word buffer and loads/stores it
// through a strobe/ack memory handshake with a bounded wait.
module fp_loader #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int AUTO_INC = 1,
  parameter int TIMEOUT  = 15
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_prog,
  input  logic                             i_key_valid,
  input  logic [3:0]                       i_key_code,
  input  logic                             i_next_pulse,
  input  logic                             i_prev_pulse,
  input  logic                             i_write_pulse,
  input  logic                             i_mem_ack,
  input  logic [DATA_W-1:0]                i_mem_rdata,
  output logic [ADDR_W-1:0]                o_mem_addr,
  output logic [DATA_W-1:0]                o_mem_wdata,
  output logic                             o_mem_we,
  output logic                             o_mem_re,
  output logic                             o_busy,
  output logic [$clog2(DATA_W/4+1)-1:0]    o_digits,
  output logic                             o_err
);
  localparam int DGW = $clog2(DATA_W/4+1);
  localparam int CW  = $clog2(TIMEOUT+1);
  typedef enum logic [1:0] {IDLE, READ, WRITE, WAITDONE} state_t;
  state_t            r_state, w_next;
  logic              r_prog_d, r_err;
  logic [CW-1:0]     r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_buf;
  logic [DGW-1:0]    r_digits;
  logic w_rise, w_act, w_wr, w_nx, w_pv, w_key, w_hs, w_to;
  logic [DATA_W-1:0] w_shift;
  // The rising edge of prog wins the cycle; panel events in that cycle are dropped.
  assign w_rise  = i_prog & ~r_prog_d;
  assign w_act   = (r_state == IDLE) & i_prog & ~r_prog_d ^ (r_state == IDLE) & i_prog;
  assign w_wr    = w_act & i_write_pulse;
  assign w_nx    = w_act & ~i_write_pulse & i_next_pulse;
  assign w_pv    = w_act & ~i_write_pulse & ~i_next_pulse & i_prev_pulse;
  assign w_key   = w_act & ~i_write_pulse & ~i_next_pulse & ~i_prev_pulse & i_key_valid;
  assign w_hs    = (r_state == READ) | (r_state == WRITE);
  assign w_to    = w_hs & ~i_mem_ack & (r_cnt == CW'(TIMEOUT-1));
  assign w_shift = DATA_W'({r_buf, i_key_code});
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = (w_rise | w_nx | w_pv) ? READ : w_wr ? WRITE : IDLE;
      READ:     w_next = (i_mem_ack | w_to) ? IDLE : READ;
      WRITE:    w_next = i_mem_ack ? WAITDONE : w_to ? IDLE : WRITE;
      WAITDONE: w_next = (AUTO_INC != 0 && i_prog) ? READ : IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_prog_d <= 1'b0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_buf    <= '0;
      r_digits <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_prog_d <= i_prog;
      r_cnt    <= (w_hs && w_next == r_state) ? r_cnt + 1'b1 : '0;
      if (w_nx || (r_state == WRITE && i_mem_ack && AUTO_INC != 0))
        r_addr <= r_addr + 1'b1;
      else if (w_pv)
        r_addr <= r_addr - 1'b1;
      if (r_state == READ && i_mem_ack) begin
        r_buf    <= i_mem_rdata;
        r_digits <= '0;
      end else if (w_key) begin
        r_buf    <= w_shift;
        r_digits <= (r_digits == DGW'(DATA_W/4)) ? r_digits : r_digits + 1'b1;
      end
      if (w_to)
        r_err <= 1'b1;
      else if (w_key || w_wr)
        r_err <= 1'b0;
    end
  end
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_buf;
  assign o_mem_we    = r_state == WRITE;
  assign o_mem_re    = r_state == READ;
  assign o_busy      = r_state != IDLE;
  assign o_digits    = r_digits;
  assign o_err       = r_err;
endmodule

// File: tb/tb_fp_loader.sv
// tb_fp_loader: randomized transaction-level check of fp_loader against a panel/memory model,
// with a default instance (A), an AUTO_INC=0 instance (B) and a wide instance (C).
module tb_fp_loader;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  int n_vec = 0, n_err = 0;
  logic       a_prog = 0, a_kv = 0, a_nx = 0, a_pv = 0, a_wr = 0, a_ack = 0;
  logic [3:0] a_kc = 0, a_addr;
  logic [7:0] a_wdata, a_rdata;
  logic       a_we, a_re, a_busy, a_err;
  logic [1:0] a_dig;
  logic       a_ack_en = 1, a_load = 0;
  int         a_lat = 0, a_wait = 0;
  logic [7:0] a_mem [16];
  logic [7:0] a_init[16];
  int         a_we_cyc = 0, a_re_cyc = 0, a_hs = 0, a_viol = 0;
  logic [3:0] a_haddr = 0;
  logic [7:0] a_hdata = 0;
  logic       a_pwa = 0, a_pra = 0;
  logic       b_prog = 0, b_nx = 0, b_pv = 0, b_wr = 0, b_ack = 0, b_we, b_re, b_busy, b_err;
  logic [3:0] b_addr;
  logic [7:0] b_wdata;
  logic [1:0] b_dig;
  int         b_re_cyc = 0, b_we_cyc = 0;
  logic       c_prog = 0, c_kv = 0, c_nx = 0, c_pv = 0, c_ack = 0, c_we, c_re, c_busy, c_err;
  logic [3:0] c_kc = 0;
  logic [7:0] c_addr;
  logic [15:0] c_wdata;
  logic [2:0] c_dig;
  logic [3:0] m_addr = 0;
  logic [7:0] m_buf = 0;
  logic [7:0] m_mem[16];
  int         m_dig = 0;

  fp_loader dut_a (.i_clk(clk), .i_reset(reset), .i_prog(a_prog), .i_key_valid(a_kv), .i_key_code(a_kc),
    .i_next_pulse(a_nx), .i_prev_pulse(a_pv), .i_write_pulse(a_wr), .i_mem_ack(a_ack), .i_mem_rdata(a_rdata),
    .o_mem_addr(a_addr), .o_mem_wdata(a_wdata), .o_mem_we(a_we), .o_mem_re(a_re), .o_busy(a_busy),
    .o_digits(a_dig), .o_err(a_err));
  fp_loader #(.AUTO_INC(0)) dut_b (.i_clk(clk), .i_reset(reset), .i_prog(b_prog), .i_key_valid(1'b0),
    .i_key_code(4'h0), .i_next_pulse(b_nx), .i_prev_pulse(b_pv), .i_write_pulse(b_wr), .i_mem_ack(b_ack),
    .i_mem_rdata(8'h00), .o_mem_addr(b_addr), .o_mem_wdata(b_wdata), .o_mem_we(b_we), .o_mem_re(b_re),
    .o_busy(b_busy), .o_digits(b_dig), .o_err(b_err));
  fp_loader #(.ADDR_W(8), .DATA_W(16)) dut_c (.i_clk(clk), .i_reset(reset), .i_prog(c_prog), .i_key_valid(c_kv),
    .i_key_code(c_kc), .i_next_pulse(c_nx), .i_prev_pulse(c_pv), .i_write_pulse(1'b0), .i_mem_ack(c_ack),
    .i_mem_rdata(16'h0000), .o_mem_addr(c_addr), .o_mem_wdata(c_wdata), .o_mem_we(c_we), .o_mem_re(c_re),
    .o_busy(c_busy), .o_digits(c_dig), .o_err(c_err));

  // Memory responders: A has a programmable ack latency and can withhold ack entirely.
  assign a_rdata = a_mem[a_addr];
  always @(posedge clk) begin
    if (a_load) for (int i = 0; i < 16; i++) a_mem[i] <= a_init[i];
    else if (a_we && a_ack) a_mem[a_addr] <= a_wdata;
    if (a_ack || !(a_we || a_re) || !a_ack_en) begin
      a_ack <= 1'b0; a_wait <= 0;
    end else if (a_wait >= a_lat) begin
      a_ack <= 1'b1; a_wait <= 0;
    end else a_wait <= a_wait + 1;
    b_ack <= (b_we | b_re) & ~b_ack;
    c_ack <= (c_we | c_re) & ~c_ack;
  end
  always @(negedge clk) begin
    a_we_cyc <= a_we_cyc + int'(a_we);
    a_re_cyc <= a_re_cyc + int'(a_re);
    b_we_cyc <= b_we_cyc + int'(b_we);
    b_re_cyc <= b_re_cyc + int'(b_re);
    if (a_we && a_ack) begin a_hs <= a_hs + 1; a_haddr <= a_addr; a_hdata <= a_wdata; end
    if ((a_we && a_re) || (!a_busy && (a_we || a_re)) || (a_pwa && a_we) || (a_pra && a_re)) a_viol <= a_viol + 1;
    a_pwa <= a_we && a_ack;
    a_pra <= a_re && a_ack;
  end

  task automatic tick; @(posedge clk); #1; endtask
  function automatic logic busy_of(input int d);
    return d == 0 ? a_busy : d == 1 ? b_busy : c_busy;
  endfunction
  task automatic wait_idle(input int d);
    for (int i = 0; i < 100; i++) begin
      if (!busy_of(d)) break;
      tick;
    end
    if (busy_of(d)) begin n_vec++; n_err++; $display("FAIL wait_idle[%0d]: busy=1 after 100 cycles, want 0", d); end
  endtask
  task automatic load_mem(input bit rnd);
    for (int i = 0; i < 16; i++) begin a_init[i] = rnd ? 8'($urandom) : 8'h00; m_mem[i] = a_init[i]; end
    a_load = 1; tick; a_load = 0;
  endtask
  // m = {write, next, prev, key}
  task automatic pulse(input logic [3:0] m, input logic [3:0] k);
    {a_wr, a_nx, a_pv, a_kv} = m; a_kc = k; tick; {a_wr, a_nx, a_pv, a_kv} = 4'b0;
  endtask
  // Reference: one accepted panel event, with the memory transactions it causes completed.
  task automatic model_step(input logic [3:0] m, input logic [3:0] k);
    if (m[3]) begin m_mem[m_addr] = m_buf; m_addr = m_addr + 4'd1; m_buf = m_mem[m_addr]; m_dig = 0; end
    else if (m[2]) begin m_addr = m_addr + 4'd1; m_buf = m_mem[m_addr]; m_dig = 0; end
    else if (m[1]) begin m_addr = m_addr - 4'd1; m_buf = m_mem[m_addr]; m_dig = 0; end
    else if (m[0]) begin m_buf = {m_buf[3:0], k}; m_dig = (m_dig < 2) ? m_dig + 1 : 2; end
  endtask

  task automatic test_reset;
    reset = 1; load_mem(0); tick;
    n_vec++; if ({a_we, a_re, a_busy, a_err} !== 4'b0) begin n_err++; $display("FAIL reset_strobes: got we/re/busy/err=%b want 0000", {a_we, a_re, a_busy, a_err}); end
    n_vec++; if (a_addr !== 4'h0 || a_wdata !== 8'h00 || a_dig !== 2'd0) begin n_err++; $display("FAIL reset_regs: got addr=%h buf=%h dig=%0d want 0/00/0", a_addr, a_wdata, a_dig); end
    reset = 0; tick; tick;
    n_vec++; if (a_busy !== 1'b0 || b_busy !== 1'b0 || c_busy !== 1'b0) begin n_err++; $display("FAIL reset_release: got busy a/b/c=%b%b%b want 000", a_busy, b_busy, c_busy); end
  endtask

  task automatic test_prog_ignore;
    pulse(4'hF, 4'h5);
    n_vec++; if (a_busy !== 1'b0 || a_addr !== 4'h0 || a_wdata !== 8'h00 || a_dig !== 2'd0) begin n_err++; $display("FAIL prog0_all: got busy=%b addr=%h buf=%h dig=%0d want 0/0/00/0", a_busy, a_addr, a_wdata, a_dig); end
    pulse(4'b0010, 4'h0);
    n_vec++; if (a_busy !== 1'b0 || a_addr !== 4'h0) begin n_err++; $display("FAIL prog0_prev: got busy=%b addr=%h want 0/0", a_busy, a_addr); end
  endtask

  task automatic test_entry;
    a_lat = 0; a_prog = 1; tick;
    n_vec++; if (a_re !== 1'b1) begin n_err++; $display("FAIL prog_rise_read: got re=%b want 1", a_re); end
    wait_idle(0);
    pulse(4'b0001, 4'h3); pulse(4'b0001, 4'hA); pulse(4'b0001, 4'h7);
    n_vec++; if (a_wdata !== 8'hA7 || a_dig !== 2'd2) begin n_err++; $display("FAIL entry_keys: got buf=%h dig=%0d want a7/2", a_wdata, a_dig); end
    pulse(4'b0010, 4'h0);
    n_vec++; if (a_addr !== 4'hF || a_re !== 1'b1) begin n_err++; $display("FAIL prev_wrap: got addr=%h re=%b want f/1", a_addr, a_re); end
    wait_idle(0);
    m_addr = 4'hF; m_buf = 8'h00; m_dig = 0;
    n_vec++; if (a_wdata !== 8'h00 || a_dig !== 2'd0) begin n_err++; $display("FAIL prev_read: got buf=%h dig=%0d want 00/0", a_wdata, a_dig); end
  endtask

  task automatic test_write_autoinc;
    int h0;
    load_mem(1);
    while (m_addr != 4'h5) begin pulse(4'b0100, 4'h0); wait_idle(0); model_step(4'b0100, 4'h0); end
    pulse(4'b0001, 4'h3); model_step(4'b0001, 4'h3);
    pulse(4'b0001, 4'hC); model_step(4'b0001, 4'hC);
    h0 = a_hs;
    pulse(4'b1000, 4'h0); wait_idle(0); model_step(4'b1000, 4'h0);
    n_vec++; if (a_hs - h0 !== 1 || a_haddr !== 4'h5 || a_hdata !== 8'h3C) begin n_err++; $display("FAIL write_hs: got n=%0d addr=%h data=%h want 1/5/3c", a_hs - h0, a_haddr, a_hdata); end
    n_vec++; if (a_addr !== 4'h6 || a_wdata !== m_mem[6]) begin n_err++; $display("FAIL write_inc_read: got addr=%h buf=%h want 6/%h", a_addr, a_wdata, m_mem[6]); end
  endtask

  task automatic test_collision;
    int h0; logic [3:0] wa, k; logic [7:0] wd;
    h0 = a_hs; wa = m_addr; wd = m_buf; k = 4'($urandom);
    pulse(4'b1101, k); pulse(4'b0100, 4'h0); wait_idle(0); model_step(4'b1000, 4'h0);
    n_vec++; if (a_hs - h0 !== 1 || a_haddr !== wa || a_hdata !== wd) begin n_err++; $display("FAIL collide_hs: got n=%0d addr=%h data=%h want 1/%h/%h", a_hs - h0, a_haddr, a_hdata, wa, wd); end
    n_vec++; if (a_addr !== m_addr || a_wdata !== m_buf) begin n_err++; $display("FAIL collide_state: got addr=%h buf=%h want %h/%h", a_addr, a_wdata, m_addr, m_buf); end
  endtask

  task automatic test_timeout;
    int w0; logic [3:0] k;
    w0 = a_we_cyc; a_ack_en = 0;
    pulse(4'b1000, 4'h0); wait_idle(0);
    n_vec++; if (a_we_cyc - w0 !== 15) begin n_err++; $display("FAIL timeout_len: got we cycles=%0d want 15", a_we_cyc - w0); end
    n_vec++; if (a_err !== 1'b1 || a_addr !== m_addr || a_wdata !== m_buf) begin n_err++; $display("FAIL timeout_state: got err=%b addr=%h buf=%h want 1/%h/%h", a_err, a_addr, a_wdata, m_addr, m_buf); end
    a_ack_en = 1; k = 4'($urandom);
    pulse(4'b0001, k); model_step(4'b0001, k);
    n_vec++; if (a_err !== 1'b0 || a_wdata !== m_buf) begin n_err++; $display("FAIL err_clear: got err=%b buf=%h want 0/%h", a_err, a_wdata, m_buf); end
  endtask

  task automatic test_prog_fall;
    int r0, h0;
    a_lat = 2; r0 = a_re_cyc; h0 = a_hs;
    pulse(4'b1000, 4'h0); a_prog = 0; tick; wait_idle(0); tick; tick;
    n_vec++; if (a_re_cyc - r0 !== 0 || a_hs - h0 !== 1 || a_busy !== 1'b0) begin n_err++; $display("FAIL prog_fall: got reads=%0d writes=%0d busy=%b want 0/1/0", a_re_cyc - r0, a_hs - h0, a_busy); end
    a_lat = 0;
  endtask

  task automatic test_reset_midwrite;
    int h0;
    a_prog = 1; tick; wait_idle(0);
    a_ack_en = 0; h0 = a_hs;
    pulse(4'b1000, 4'h0); tick;
    n_vec++; if (a_we !== 1'b1) begin n_err++; $display("FAIL midwrite_we: got we=%b want 1", a_we); end
    #2 reset = 1; #1;
    n_vec++; if (a_we !== 1'b0 || a_re !== 1'b0 || a_busy !== 1'b0) begin n_err++; $display("FAIL async_drop: got we/re/busy=%b%b%b want 000", a_we, a_re, a_busy); end
    a_prog = 0; a_ack_en = 1; tick; reset = 0; tick; tick; tick;
    n_vec++; if ({a_we, a_re, a_busy, a_err} !== 4'b0 || a_addr !== 4'h0 || a_wdata !== 8'h00 || a_dig !== 2'd0 || a_hs != h0) begin n_err++; $display("FAIL after_reset: got we/re/busy/err=%b addr=%h buf=%h dig=%0d writes=%0d want 0000/0/00/0/0", {a_we, a_re, a_busy, a_err}, a_addr, a_wdata, a_dig, a_hs - h0); end
    m_addr = 0; m_buf = 0; m_dig = 0;
  endtask

  task automatic test_random;
    load_mem(1);
    a_prog = 1; tick; wait_idle(0); m_buf = m_mem[0];
    for (int i = 0; i < 40; i++) begin
      automatic logic [3:0] m = 4'($urandom_range(1, 15));
      automatic logic [3:0] k = 4'($urandom);
      a_lat = $urandom_range(0, 3);
      pulse(m, k); wait_idle(0); model_step(m, k);
      n_vec++; if (a_addr !== m_addr) begin n_err++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, a_addr, m_addr); end
      n_vec++; if (a_wdata !== m_buf) begin n_err++; $display("FAIL rnd_buf[%0d]: got %h want %h", i, a_wdata, m_buf); end
      n_vec++; if (int'(a_dig) !== m_dig) begin n_err++; $display("FAIL rnd_digits[%0d]: got %0d want %0d", i, a_dig, m_dig); end
      n_vec++; if (a_err !== 1'b0) begin n_err++; $display("FAIL rnd_err[%0d]: got %b want 0", i, a_err); end
    end
    a_lat = 0;
  endtask

  task automatic test_noinc;
    int r0, w0;
    b_prog = 1; tick; wait_idle(1);
    b_pv = 1; tick; b_pv = 0; wait_idle(1);
    n_vec++; if (b_addr !== 4'hF) begin n_err++; $display("FAIL noinc_prev: got addr=%h want f", b_addr); end
    r0 = b_re_cyc; w0 = b_we_cyc;
    b_wr = 1; tick; b_wr = 0; wait_idle(1); tick; tick;
    n_vec++; if (b_addr !== 4'hF || b_re_cyc - r0 !== 0 || b_we_cyc - w0 < 1 || b_busy !== 1'b0) begin n_err++; $display("FAIL noinc_write: got addr=%h reads=%0d we_cycles=%0d busy=%b want f/0/>0/0", b_addr, b_re_cyc - r0, b_we_cyc - w0, b_busy); end
  endtask

  task automatic test_param;
    c_prog = 1; tick; wait_idle(2);
    for (int k = 1; k <= 5; k++) begin c_kv = 1; c_kc = 4'(k); tick; c_kv = 0; end
    n_vec++; if (c_wdata !== 16'h2345 || c_dig !== 3'd4) begin n_err++; $display("FAIL wide_keys: got buf=%h dig=%0d want 2345/4", c_wdata, c_dig); end
    c_pv = 1; tick; c_pv = 0; wait_idle(2);
    n_vec++; if (c_addr !== 8'hFF) begin n_err++; $display("FAIL wide_prev: got addr=%h want ff", c_addr); end
    c_nx = 1; tick; c_nx = 0; wait_idle(2);
    n_vec++; if (c_addr !== 8'h00 || c_err !== 1'b0) begin n_err++; $display("FAIL wide_next_wrap: got addr=%h err=%b want 00/0", c_addr, c_err); end
  endtask

  task automatic test_invariants;
    n_vec++; if (a_viol !== 0) begin n_err++; $display("FAIL strobe_rules: got %0d violating cycles want 0", a_viol); end
  endtask

  initial begin
    test_reset;
    test_prog_ignore;
    test_entry;
    test_write_autoinc;
    test_collision;
    test_timeout;
    test_prog_fall;
    test_reset_midwrite;
    test_random;
    test_noinc;
    test_param;
    test_invariants;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
